// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered RV immediate decoder with a DEPTH-entry
// valid/ready output FIFO and a saturating illegal-opcode counter.
// Optional feature macro: ZICSR_EN (decode CSR immediate forms as ZIMM).
module imm_decode_stage #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_out,
   output logic [2:0]       imm_type,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [2:0] T_NONE  = 3'd0;
   localparam logic [2:0] T_I     = 3'd1;
   localparam logic [2:0] T_S     = 3'd2;
   localparam logic [2:0] T_B     = 3'd3;
   localparam logic [2:0] T_U     = 3'd4;
   localparam logic [2:0] T_J     = 3'd5;
   localparam logic [2:0] T_SHAMT = 3'd6;
`ifdef ZICSR_EN
   localparam logic [2:0] T_ZIMM  = 3'd7;
`endif

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      typ;
      logic            ill;
   } entry_t;

   // Sign-extend a 32-bit pre-extended immediate out to XLEN.
   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic signed [31:0] s;
      s = signed'(v);
      return XLEN'(s);
   endfunction

   // Shift amount field is one bit wider on RV64.
   function automatic logic [XLEN-1:0] shamt(input logic [31:0] ins);
      if (XLEN == 64) return XLEN'(ins[25:20]);
      else            return XLEN'(ins[24:20]);
   endfunction

   function automatic entry_t decode(input logic [31:0] ins);
      entry_t     e;
      logic [2:0] f3;
      e  = '0;
      f3 = ins[14:12];
      case (ins[6:0])
         OPC_OP_IMM: begin
            if (f3 == 3'b001 || f3 == 3'b101) begin
               e.typ = T_SHAMT;
               e.imm = shamt(ins);
            end else begin
               e.typ = T_I;
               e.imm = sext32({{20{ins[31]}}, ins[31:20]});
            end
         end
         OPC_LOAD, OPC_JALR: begin
            e.typ = T_I;
            e.imm = sext32({{20{ins[31]}}, ins[31:20]});
         end
         OPC_STORE: begin
            e.typ = T_S;
            e.imm = sext32({{20{ins[31]}}, ins[31:25], ins[11:7]});
         end
         OPC_BRANCH: begin
            e.typ = T_B;
            e.imm = sext32({{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
         end
         OPC_LUI, OPC_AUIPC: begin
            e.typ = T_U;
            e.imm = sext32({ins[31:12], 12'b0});
         end
         OPC_JAL: begin
            e.typ = T_J;
            e.imm = sext32({{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
         end
         OPC_SYSTEM: begin
`ifdef ZICSR_EN
            if (f3[2]) begin
               e.typ = T_ZIMM;
               e.imm = XLEN'(ins[19:15]);
            end
`endif
         end
         OPC_OP, OPC_FENCE: e.typ = T_NONE;
         default:           e.ill = 1'b1;
      endcase
      return e;
   endfunction

   // Saturating increment: the counter parks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + CNT_W'(1);
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   entry_t          mem_q [DEPTH];
   entry_t          last_q, last_d;
   entry_t          dec_e, head_e, out_e;
   logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0] icnt_q, icnt_d;
   logic            full, push, pop;

   assign dec_e     = decode(instr);
   assign head_e    = mem_q[rd_q];
   assign full      = (cnt_q == CW'(DEPTH));
   assign out_valid = (cnt_q != '0);
   assign in_ready  = !full || out_ready;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // While empty the outputs replay the last entry handed to the consumer.
   assign out_e       = out_valid ? head_e : last_q;
   assign imm_out     = out_e.imm;
   assign imm_type    = out_e.typ;
   assign illegal     = out_e.ill;
   assign illegal_cnt = icnt_q;

   // Next-state for pointers, occupancy, replay register and illegal counter.
   always_comb begin
      wr_d   = wr_q;
      rd_d   = rd_q;
      cnt_d  = cnt_q;
      last_d = last_q;
      icnt_d = icnt_q;
      if (pop) last_d = head_e;
      // Counted at acceptance, so instructions later flushed still count.
      if (push && dec_e.ill) icnt_d = sat_inc(icnt_q);
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) wr_d = ptr_inc(wr_q);
         if (pop)  rd_d = ptr_inc(rd_q);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Control and visible output state, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         last_q <= '0;
         icnt_q <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         last_q <= last_d;
         icnt_q <= icnt_d;
      end
   end

   // Entry storage; contents are only meaningful while counted as occupied.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= dec_e;
   end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: default instance plus an XLEN=64
// instance and a CNT_W=2 instance that mirror every accepted instruction.
module tb_imm_decode_stage;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [31:0] instr;

   logic        in_ready, out_valid, illegal;
   logic [31:0] imm_out;
   logic [2:0]  imm_type;
   logic [15:0] illegal_cnt;

   logic        aux_valid;
   logic        r64_in_ready, r64_out_valid, r64_illegal;
   logic [63:0] r64_imm;
   logic [2:0]  r64_type;
   logic [15:0] r64_cnt;

   logic        rs_in_ready, rs_out_valid, rs_illegal;
   logic [31:0] rs_imm;
   logic [2:0]  rs_type;
   logic [1:0]  rs_cnt;

   assign aux_valid = in_valid && in_ready;

   imm_decode_stage u_dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .imm_out(imm_out),
      .imm_type(imm_type), .illegal(illegal), .illegal_cnt(illegal_cnt));

   imm_decode_stage #(.XLEN(64)) u_x64 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(aux_valid), .in_ready(r64_in_ready),
      .instr(instr), .out_valid(r64_out_valid), .out_ready(1'b1), .imm_out(r64_imm),
      .imm_type(r64_type), .illegal(r64_illegal), .illegal_cnt(r64_cnt));

   imm_decode_stage #(.CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(aux_valid), .in_ready(rs_in_ready),
      .instr(instr), .out_valid(rs_out_valid), .out_ready(1'b1), .imm_out(rs_imm),
      .imm_type(rs_type), .illegal(rs_illegal), .illegal_cnt(rs_cnt));

   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] imm; logic [2:0] t; logic ill; } exp32_t;
   typedef struct packed { logic [63:0] imm; logic [2:0] t; logic ill; } exp64_t;

   exp32_t q32[$];
   exp64_t q64[$];
   exp32_t m32;
   exp64_t m64;
   int checks = 0;
   int errors = 0;

`ifdef ZICSR_EN
   localparam logic [31:0] CSRI_E32 = 32'h0000000F;
   localparam logic [63:0] CSRI_E64 = 64'h000000000000000F;
   localparam logic [2:0]  CSRI_T   = 3'd7;
`else
   localparam logic [31:0] CSRI_E32 = 32'h0;
   localparam logic [63:0] CSRI_E64 = 64'h0;
   localparam logic [2:0]  CSRI_T   = 3'd0;
`endif

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Main-instance monitor: compares every popped head entry.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (q32.size() == 0) begin
            checks++; errors++;
            $display("FAIL main_unexpected actual=0x%0h required=no_output", imm_out);
         end else begin
            m32 = q32.pop_front();
            chk("main_imm", 64'(imm_out), 64'(m32.imm));
            chk("main_type", 64'(imm_type), 64'(m32.t));
            chk("main_illegal", 64'(illegal), 64'(m32.ill));
         end
      end
   end

   // XLEN=64 instance monitor.
   always @(negedge clk) begin
      if (!reset && r64_out_valid) begin
         if (q64.size() == 0) begin
            checks++; errors++;
            $display("FAIL x64_unexpected actual=0x%0h required=no_output", r64_imm);
         end else begin
            m64 = q64.pop_front();
            chk("x64_imm", r64_imm, m64.imm);
            chk("x64_type", 64'(r64_type), 64'(m64.t));
            chk("x64_illegal", 64'(r64_illegal), 64'(m64.ill));
         end
      end
   end

   task automatic push_exp(input logic [31:0] e32, input logic [63:0] e64,
                           input logic [2:0] t, input logic ill);
      q32.push_back({e32, t, ill});
      q64.push_back({e64, t, ill});
   endtask

   // Starts and ends at posedge+1; expectation queued when the handshake is seen.
   task automatic send(input logic [31:0] ins, input logic [31:0] e32, input logic [63:0] e64,
                       input logic [2:0] t, input logic ill);
      bit done = 1'b0;
      in_valid = 1'b1;
      instr    = ins;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            push_exp(e32, e64, t, ill);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL send_timeout actual=not_accepted required=accepted instr=0x%0h", ins);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_imm", 64'(imm_out), 64'd0);
      chk("rst_type", 64'(imm_type), 64'd0);
      chk("rst_illegal", 64'(illegal), 64'd0);
      chk("rst_cnt", 64'(illegal_cnt), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      out_ready = 1'b1;

      // Decode coverage with a free-running consumer
      send(32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
      @(negedge clk);
      chk("latency_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      send(32'hFE20AE23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
      send(32'h800002B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
      send(32'h12345017, 32'h12345000, 64'h0000000012345000, 3'd4, 1'b0);
      send(32'hFFFFF06F, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 3'd5, 1'b0);
      send(32'h01F09093, 32'h0000001F, 64'h000000000000001F, 3'd6, 1'b0);
      send(32'h03F09093, 32'h0000001F, 64'h000000000000003F, 3'd6, 1'b0);
      send(32'h4050D093, 32'h00000005, 64'h0000000000000005, 3'd6, 1'b0);
      send(32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
      send(32'hFFF12083, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
      send(32'h008080E7, 32'h00000008, 64'h0000000000000008, 3'd1, 1'b0);
      send(32'h003100B3, 32'h0, 64'h0, 3'd0, 1'b0);
      send(32'h0FF0000F, 32'h0, 64'h0, 3'd0, 1'b0);
      send(32'h00000073, 32'h0, 64'h0, 3'd0, 1'b0);
      send(32'h3407D073, CSRI_E32, CSRI_E64, CSRI_T, 1'b0);
      send(32'h30009073, 32'h0, 64'h0, 3'd0, 1'b0);
      idle(3);

      // Backpressure: fill, stall a third push, then pop and push together
      out_ready = 1'b0;
      send(32'h00500093, 32'h5, 64'h5, 3'd1, 1'b0);
      send(32'hFFF12083, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
      in_valid = 1'b1; instr = 32'h008080E7;
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_out_valid", 64'(out_valid), 64'd1);
      chk("full_hold_imm", 64'(imm_out), 64'h5);
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_hold_imm", 64'(imm_out), 64'h5);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("full_pop_push_ready", 64'(in_ready), 64'd1);
      if (in_ready) push_exp(32'h8, 64'h8, 3'd1, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      idle(4);

      // Illegal opcodes and counter saturation
      repeat (3) send(32'h0000007F, 32'h0, 64'h0, 3'd0, 1'b1);
      idle(2);
      chk("ill_cnt3", 64'(illegal_cnt), 64'd3);
      chk("sat_cnt3", 64'(rs_cnt), 64'd3);
      repeat (2) send(32'h0000007F, 32'h0, 64'h0, 3'd0, 1'b1);
      idle(2);
      chk("ill_cnt5", 64'(illegal_cnt), 64'd5);
      chk("sat_cnt_hold", 64'(rs_cnt), 64'd3);
      chk("empty_hold_illegal", 64'(illegal), 64'd1);
      chk("empty_out_valid", 64'(out_valid), 64'd0);

      // Flush with two buffered entries
      out_ready = 1'b0;
      send(32'h00500093, 32'h5, 64'h5, 3'd1, 1'b0);
      send(32'h800002B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
      idle(1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      q32.delete();
      @(negedge clk);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_hold_illegal", 64'(illegal), 64'd1);
      @(posedge clk); #1;

      // Flush that coincides with an illegal push: entry dropped, still counted
      send(32'h00500093, 32'h5, 64'h5, 3'd1, 1'b0);
      flush = 1'b1; in_valid = 1'b1; instr = 32'h0000007F;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      q32.delete();
      @(negedge clk);
      chk("flush_push_out_valid", 64'(out_valid), 64'd0);
      chk("flush_push_cnt", 64'(illegal_cnt), 64'd6);
      chk("flush_sat_cnt", 64'(rs_cnt), 64'd3);
      @(posedge clk); #1;
      idle(2);

      // Asynchronous reset with two buffered entries
      send(32'h00500093, 32'h5, 64'h5, 3'd1, 1'b0);
      send(32'hFE20AE23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_imm", 64'(imm_out), 64'd0);
      chk("mid_rst_illegal", 64'(illegal), 64'd0);
      chk("mid_rst_cnt", 64'(illegal_cnt), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      q32.delete();
      q64.delete();
      out_ready = 1'b1;
      send(32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
      send(32'h0000007F, 32'h0, 64'h0, 3'd0, 1'b1);
      idle(3);
      chk("post_rst_cnt", 64'(illegal_cnt), 64'd1);
      chk("q32_drained", 64'(q32.size()), 64'd0);
      chk("q64_drained", 64'(q64.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
